// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes loads/stores, sequences data-memory access, and forms the MEM/WB register.
// Optional misalignment detection (adelW/adesW outputs) is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] pcplusM,
  output logic        stallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] instrW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic [31:0] pcplusW
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        adelW,
  output logic        adesW
`endif
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  state_t      state_reg, state_next;
  logic [5:0]  opcode;
  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misaligned, mem_op;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rdata_sel, rdata_next;
  logic [7:0]  rd_byte [4];
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign opcode   = instrM[31:26];
  assign is_load  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                    (opcode == OP_LBU) || (opcode == OP_LHU);
  assign is_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  assign is_byte  = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
  assign is_half  = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
  assign is_word  = (opcode == OP_LW) || (opcode == OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_word && (ALUOutM[1:0] != 2'b00)) || (is_half && ALUOutM[0]);
`else
  assign misaligned = 1'b0;
`endif
  // Misaligned ops bypass memory entirely and retire like non-memory instructions.
  assign mem_op = (is_load || is_store) && !misaligned;

  assign dmem_addr = {ALUOutM[31:2], 2'b00};

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = WriteDataM;
    if (is_store && is_byte) begin
      be_calc    = 4'b0001 << ALUOutM[1:0];
      wdata_calc = {4{WriteDataM[7:0]}};
    end else if (is_store && is_half) begin
      be_calc    = ALUOutM[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{WriteDataM[15:0]}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  assign lane_byte = rd_byte[ALUOutM[1:0]];
  assign lane_half = ALUOutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (opcode)
      OP_LB:   rdata_sel = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  rdata_sel = {24'h0, lane_byte};
      OP_LH:   rdata_sel = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  rdata_sel = {16'h0, lane_half};
      OP_LW:   rdata_sel = dmem_rdata;
      default: rdata_sel = 32'h0;
    endcase
  end

  assign rdata_next = (mem_op && is_load) ? rdata_sel : 32'h0;

  always_comb begin
    state_next = state_reg;
    stallM     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = 32'h0;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          state_next = ACCESS;
          stallM     = 1'b1;
        end
      end
      ACCESS: begin
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        dmem_be    = be_calc;
        dmem_wdata = is_store ? wdata_calc : 32'h0;
        if (dmem_ack) state_next = IDLE;
        else          stallM     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      instrW    <= 32'h0;
      ALUOutW   <= 32'h0;
      ReadDataW <= 32'h0;
      pcplusW   <= 32'h0000_3008;
    end else begin
      state_reg <= state_next;
      if (stallM) begin
        instrW    <= 32'h0;
        ALUOutW   <= 32'h0;
        ReadDataW <= 32'h0;
      end else begin
        instrW    <= instrM;
        ALUOutW   <= ALUOutM;
        ReadDataW <= rdata_next;
        pcplusW   <= pcplusM;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adelW <= 1'b0;
      adesW <= 1'b0;
    end else begin
      adelW <= !stallM && misaligned && is_load;
      adesW <= !stallM && misaligned && is_store;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: reset, ALU pass-through, load lanes, stalled store, reset abort.
// Alignment-flag steps are included when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage_ctrl;
  logic        clk, rst;
  logic [31:0] instrM, ALUOutM, WriteDataM, pcplusM;
  logic        stallM, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] instrW, ALUOutW, ReadDataW, pcplusW;
`ifdef MEM_ALIGN_CHECK_EN
  logic        adelW, adesW;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [31:0] I_ADDU = 32'h0085_1021;
  localparam logic [31:0] I_LB   = 32'h8082_0003;
  localparam logic [31:0] I_LH   = 32'h8482_0000;
  localparam logic [31:0] I_LW   = 32'h8C82_0000;
  localparam logic [31:0] I_LBU  = 32'h9082_0003;
  localparam logic [31:0] I_SB   = 32'hA082_0000;
  localparam logic [31:0] I_SH   = 32'hA482_0000;
  localparam logic [31:0] I_SW   = 32'hAC82_0000;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .instrM(instrM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .pcplusM(pcplusM),
    .stallM(stallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .instrW(instrW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .pcplusW(pcplusW)
`ifdef MEM_ALIGN_CHECK_EN
    , .adelW(adelW), .adesW(adesW)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load with ack present from the start: a single IDLE stall, then one ACCESS cycle.
  task automatic do_load(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] exp_data);
    instrM = ins; ALUOutM = addr; dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    chk({tag, "_idle_stall"}, {31'h0, stallM}, 32'h1);
    chk({tag, "_idle_req"}, {31'h0, dmem_req}, 32'h0);
    tick();
    chk({tag, "_bubble"}, instrW, 32'h0);
    #1;
    chk({tag, "_req"}, {31'h0, dmem_req}, 32'h1);
    chk({tag, "_be"}, {28'h0, dmem_be}, 32'hF);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_stall"}, {31'h0, stallM}, 32'h0);
    tick();
    chk({tag, "_instrW"}, instrW, ins);
    chk({tag, "_rdata"}, ReadDataW, exp_data);
    $display("load %s addr=%h ReadDataW=%h", tag, addr, ReadDataW);
  endtask

  initial begin
    rst = 1'b1; instrM = 32'h0; ALUOutM = 32'h0; WriteDataM = 32'h0; pcplusM = 32'h0;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;
    #1;
    chk("rst_pcplusW", pcplusW, 32'h0000_3008);
    chk("rst_instrW", instrW, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stallM}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    $display("reset pcplusW=%h", pcplusW);

    // ALU instruction passes straight through in one cycle
    instrM = I_ADDU; ALUOutM = 32'h0000_1234; pcplusM = 32'h0000_3004;
    #1;
    chk("addu_stall", {31'h0, stallM}, 32'h0);
    chk("addu_be", {28'h0, dmem_be}, 32'h0);
    tick();
    chk("addu_instrW", instrW, I_ADDU);
    chk("addu_ALUOutW", ALUOutW, 32'h0000_1234);
    chk("addu_rdata", ReadDataW, 32'h0);
    chk("addu_pcplusW", pcplusW, 32'h0000_3004);
    $display("addu instrW=%h ALUOutW=%h", instrW, ALUOutW);

    // lb: pcplusW must hold through the bubble, then update
    pcplusM = 32'h0000_3010;
    do_load("lb", I_LB, 32'h0000_0013, 32'hFFFF_FF80);
    chk("lb_pcplusW", pcplusW, 32'h0000_3010);
    do_load("lbu", I_LBU, 32'h0000_0013, 32'h0000_0080);
    do_load("lh", I_LH, 32'h0000_0102, 32'hFFFF_80FF);
    do_load("lw", I_LW, 32'h0000_0020, 32'h80FF_1234);

    // sh with three ack-less ACCESS cycles
    instrM = I_SH; ALUOutM = 32'h0000_0102; WriteDataM = 32'hAAAA_5678; dmem_ack = 1'b0;
    #1;
    chk("sh_idle_stall", {31'h0, stallM}, 32'h1);
    chk("sh_idle_we", {31'h0, dmem_we}, 32'h0);
    tick();
    chk("sh_bubble1", instrW, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("sh_wait_req", {31'h0, dmem_req}, 32'h1);
      chk("sh_wait_we", {31'h0, dmem_we}, 32'h1);
      chk("sh_wait_be", {28'h0, dmem_be}, 32'hC);
      chk("sh_wait_wdata", dmem_wdata, 32'h5678_5678);
      chk("sh_wait_stall", {31'h0, stallM}, 32'h1);
      tick();
      chk("sh_bubble", instrW, 32'h0);
    end
    dmem_ack = 1'b1;
    #1;
    chk("sh_ack_stall", {31'h0, stallM}, 32'h0);
    tick();
    chk("sh_instrW", instrW, I_SH);
    chk("sh_rdata", ReadDataW, 32'h0);
    $display("store sh be=c wdata=56785678 retired instrW=%h", instrW);

    // sb byte-enable shift and replication
    instrM = I_SB; ALUOutM = 32'h0000_0011; WriteDataM = 32'h1234_5699;
    tick();
    #1;
    chk("sb_be", {28'h0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h9999_9999);
    tick();
    chk("sb_instrW", instrW, I_SB);
    $display("store sb be=%h instrW=%h", 4'h2, instrW);

    // rst during second ACCESS cycle of lw
    instrM = I_LW; ALUOutM = 32'h0000_0200; pcplusM = 32'h0000_3020; dmem_ack = 1'b0;
    tick();
    #1;
    chk("abort_req1", {31'h0, dmem_req}, 32'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_req", {31'h0, dmem_req}, 32'h0);
    chk("abort_instrW", instrW, 32'h0);
    chk("abort_ALUOutW", ALUOutW, 32'h0);
    chk("abort_pcplusW", pcplusW, 32'h0000_3008);
    instrM = 32'h0; dmem_ack = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_late_ack", {31'h0, dmem_req}, 32'h0);
    chk("abort_late_stall", {31'h0, stallM}, 32'h0);
    tick();
    chk("abort_after_instrW", instrW, 32'h0);
    chk("abort_after_rdata", ReadDataW, 32'h0);
    $display("reset abort req=%b pcplusW=%h", dmem_req, pcplusW);

`ifdef MEM_ALIGN_CHECK_EN
    instrM = I_LW; ALUOutM = 32'h0000_0101; dmem_ack = 1'b0;
    #1;
    chk("adel_stall", {31'h0, stallM}, 32'h0);
    chk("adel_req", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("adel_flag", {31'h0, adelW}, 32'h1);
    chk("adel_rdata", ReadDataW, 32'h0);
    chk("adel_instrW", instrW, I_LW);
    instrM = I_SW; ALUOutM = 32'h0000_0102;
    #1;
    chk("ades_req", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("ades_flag", {31'h0, adesW}, 32'h1);
    chk("ades_adel", {31'h0, adelW}, 32'h0);
    instrM = I_ADDU;
    tick();
    chk("align_clear", {30'h0, adelW, adesW}, 32'h0);
    $display("align adel/ades checks done");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
